// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the IF/ID pipeline buffer: instruction encodings,
// opcode field layout, FSM state encoding and the immediate-class decoder.
package if_id_buffer_pkg;

   // Canonical no-operation word driven to decode during bubbles and flushes.
   localparam logic [15:0] NOP_WORD = 16'h0000;

   // Opcode field position inside an instruction word.
   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 11;

   // Opcodes whose two top bits match this prefix carry a trailing immediate word.
   localparam logic [1:0] IMM_CLASS = 2'b11;

   // Legacy state encodings, kept as explicit constants for compatibility.
   localparam logic [0:0] S_INSTR_ENC = 1'b0;
   localparam logic [0:0] S_IMM_ENC   = 1'b1;

   typedef enum logic [0:0] {
      S_INSTR = S_INSTR_ENC,   // expecting an opcode word
      S_IMM   = S_IMM_ENC      // expecting the immediate word of a held opcode
   } state_e;

   // True when the word's opcode belongs to the immediate-bearing class.
   function automatic logic is_imm_op(input logic [15:0] word);
      logic [OPC_MSB-OPC_LSB:0] opc;
      opc = word[OPC_MSB:OPC_LSB];
      return (opc[OPC_MSB-OPC_LSB -: 2] == IMM_CLASS);
   endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer. Passes single-word instructions through with one
// cycle of latency and assembles opcode+immediate pairs over two cycles,
// inserting one bubble. Supports hazard stalls and branch/interrupt flushes.
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic               stall,
   input  logic               flush,
   output logic               fetch_en,
   output logic [INSTR_W-1:0] instr_out,
   output logic [INSTR_W-1:0] imm_out,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               has_imm_out,
   output logic               valid_out
);

   localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_WORD);

   state_e               state_q, state_d;
   logic [INSTR_W-1:0]   hold_instr_q, hold_instr_d;
   logic [ADDR_W-1:0]    hold_pc_q, hold_pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [INSTR_W-1:0]   imm_q, imm_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic                 has_imm_q, has_imm_d;
   logic                 valid_q, valid_d;

   // Fetch advances whenever the hazard unit is not holding the pipeline.
   always_comb begin
      fetch_en = ~stall;
   end

   // Next-state logic: flush dominates stall; stall freezes everything.
   always_comb begin
      state_d      = state_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      instr_d      = instr_q;
      imm_d        = imm_q;
      pc_d         = pc_q;
      has_imm_d    = has_imm_q;
      valid_d      = valid_q;

      if (flush) begin
         state_d      = S_INSTR;
         hold_instr_d = '0;
         hold_pc_d    = '0;
         instr_d      = NOP;
         imm_d        = '0;
         pc_d         = '0;
         has_imm_d    = 1'b0;
         valid_d      = 1'b0;
      end else if (!stall) begin
         case (state_q)
            S_INSTR: begin
               if (is_imm_op(16'(instr_in))) begin
                  // Park the opcode until its immediate arrives; emit a bubble.
                  hold_instr_d = instr_in;
                  hold_pc_d    = pc_in;
                  instr_d      = NOP;
                  imm_d        = '0;
                  has_imm_d    = 1'b0;
                  valid_d      = 1'b0;
                  state_d      = S_IMM;
               end else begin
                  instr_d   = instr_in;
                  pc_d      = pc_in;
                  imm_d     = '0;
                  has_imm_d = 1'b0;
                  valid_d   = 1'b1;
               end
            end
            S_IMM: begin
               instr_d   = hold_instr_q;
               pc_d      = hold_pc_q;
               imm_d     = instr_in;
               has_imm_d = 1'b1;
               valid_d   = 1'b1;
               state_d   = S_INSTR;
            end
            default: state_d = S_INSTR;
         endcase
      end
   end

   // State and output registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_INSTR;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         instr_q      <= NOP;
         imm_q        <= '0;
         pc_q         <= '0;
         has_imm_q    <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         instr_q      <= instr_d;
         imm_q        <= imm_d;
         pc_q         <= pc_d;
         has_imm_q    <= has_imm_d;
         valid_q      <= valid_d;
      end
   end

   assign instr_out   = instr_q;
   assign imm_out     = imm_q;
   assign pc_out      = pc_q;
   assign has_imm_out = has_imm_q;
   assign valid_out   = valid_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for the IF/ID buffer: directed vectors push expected
// completed instructions; a negedge monitor pops and compares each new one.
module tb_if_id_buffer;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] imm;
      logic [31:0] pc;
      logic        has;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [15:0] instr_in;
   logic [31:0] pc_in;
   logic        stall;
   logic        flush;
   logic        fetch_en;
   logic [15:0] instr_out;
   logic [15:0] imm_out;
   logic [31:0] pc_out;
   logic        has_imm_out;
   logic        valid_out;

   int unsigned checks = 0;
   int unsigned errors = 0;
   exp_t        sb[$];
   logic        hold_edge = 1'b0;

   if_id_buffer #(.ADDR_W(32), .INSTR_W(16)) dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
      .stall(stall), .flush(flush), .fetch_en(fetch_en),
      .instr_out(instr_out), .imm_out(imm_out), .pc_out(pc_out),
      .has_imm_out(has_imm_out), .valid_out(valid_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Remember whether the last edge was a pure stall, so a held valid is not re-counted.
   always @(posedge clk) hold_edge <= stall && !flush && !rst;

   // Monitor: every freshly presented valid instruction must match the queue head.
   always @(negedge clk) begin
      if (!rst && valid_out && !hold_edge) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got instr %h pc %h expected no output", instr_out, pc_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_instr", 32'(instr_out), 32'(e.instr));
            chk("sb_pc", pc_out, e.pc);
            chk("sb_imm", 32'(imm_out), 32'(e.imm));
            chk("sb_has_imm", 32'(has_imm_out), 32'(e.has));
         end
      end
   end

   task automatic push(input logic [15:0] ins, input logic [31:0] pc,
                       input logic [15:0] imm, input logic has);
      exp_t e;
      e.instr = ins; e.pc = pc; e.imm = imm; e.has = has;
      sb.push_back(e);
   endtask

   // Drive one vector at a negedge, check fetch_en, wait through the capturing edge.
   task automatic cycle(input logic [15:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl);
      instr_in = ins; pc_in = pc; stall = st; flush = fl;
      #1;
      chk("fetch_en", 32'(fetch_en), 32'(!st));
      @(negedge clk);
   endtask

   task automatic chk_bubble(input string name);
      chk({name, "_valid"}, 32'(valid_out), 32'd0);
      chk({name, "_instr"}, 32'(instr_out), 32'h0000);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0; instr_in = '0; pc_in = '0;
      #1 rst = 1'b1;
      #1;
      chk("rst_instr", 32'(instr_out), 32'h0);
      chk("rst_imm", 32'(imm_out), 32'h0);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_has_imm", 32'(has_imm_out), 32'h0);
      chk("rst_valid", 32'(valid_out), 32'h0);
      chk("rst_fetch_en", 32'(fetch_en), 32'h1);
      stall = 1'b1;
      #1 chk("rst_fetch_en_stall", 32'(fetch_en), 32'h0);
      stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single-word instruction, one cycle latency
      push(16'h0801, 32'h20, 16'h0, 1'b0);
      cycle(16'h0801, 32'h20, 1'b0, 1'b0);

      // Immediate pair with one bubble
      cycle(16'hC005, 32'h21, 1'b0, 1'b0);
      chk_bubble("imm_bubble");
      push(16'hC005, 32'h21, 16'h1234, 1'b1);
      cycle(16'h1234, 32'h22, 1'b0, 1'b0);

      // Stall three cycles holds the assembled output
      for (int i = 0; i < 3; i++) begin
         cycle(16'h0801, 32'h30, 1'b1, 1'b0);
         chk("stall_instr", 32'(instr_out), 32'hC005);
         chk("stall_pc", pc_out, 32'h21);
         chk("stall_imm", 32'(imm_out), 32'h1234);
         chk("stall_valid", 32'(valid_out), 32'h1);
      end
      push(16'h0801, 32'h30, 16'h0, 1'b0);
      cycle(16'h0801, 32'h30, 1'b0, 1'b0);

      // Flush in the immediate-wait state discards the held opcode
      cycle(16'hC005, 32'h40, 1'b0, 1'b0);
      cycle(16'h5555, 32'h41, 1'b0, 1'b1);
      chk_bubble("flush");
      chk("flush_pc", pc_out, 32'h0);
      chk("flush_imm", 32'(imm_out), 32'h0);
      chk("flush_has_imm", 32'(has_imm_out), 32'h0);
      push(16'h0801, 32'h42, 16'h0, 1'b0);
      cycle(16'h0801, 32'h42, 1'b0, 1'b0);

      // Flush and stall together: flush wins
      cycle(16'hC005, 32'h50, 1'b0, 1'b0);
      cycle(16'h1111, 32'h51, 1'b1, 1'b1);
      chk_bubble("flush_stall");
      chk("flush_stall_pc", pc_out, 32'h0);

      // Stall while waiting for the immediate keeps the held opcode
      cycle(16'hC005, 32'h52, 1'b0, 1'b0);
      cycle(16'h9999, 32'h53, 1'b1, 1'b0);
      chk_bubble("stall_imm_wait");
      cycle(16'h9999, 32'h53, 1'b1, 1'b0);
      push(16'hC005, 32'h52, 16'hABCD, 1'b1);
      cycle(16'hABCD, 32'h53, 1'b0, 1'b0);

      // Back-to-back immediate instructions; an immediate that looks like an opcode
      cycle(16'hC005, 32'h60, 1'b0, 1'b0);
      push(16'hC005, 32'h60, 16'h0001, 1'b1);
      cycle(16'h0001, 32'h61, 1'b0, 1'b0);
      cycle(16'hD00F, 32'h62, 1'b0, 1'b0);
      chk_bubble("b2b_bubble");
      push(16'hD00F, 32'h62, 16'hF000, 1'b1);
      cycle(16'hF000, 32'h63, 1'b0, 1'b0);

      // Opcode prefixes 10 and 01 are not immediate-bearing
      push(16'hB800, 32'h64, 16'h0, 1'b0);
      cycle(16'hB800, 32'h64, 1'b0, 1'b0);
      push(16'h6800, 32'h65, 16'h0, 1'b0);
      cycle(16'h6800, 32'h65, 1'b0, 1'b0);

      // Asynchronous reset mid immediate-wait
      push(16'h0801, 32'h70, 16'h0, 1'b0);
      cycle(16'h0801, 32'h70, 1'b0, 1'b0);
      cycle(16'hC005, 32'h71, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("arst_pc", pc_out, 32'h0);
      chk("arst_instr", 32'(instr_out), 32'h0);
      chk("arst_valid", 32'(valid_out), 32'h0);
      chk("arst_has_imm", 32'(has_imm_out), 32'h0);
      #1 rst = 1'b0;
      instr_in = 16'h0801; pc_in = 32'h80;
      push(16'h0801, 32'h80, 16'h0, 1'b0);
      @(negedge clk);

      // Drain with flush and confirm nothing was lost
      cycle(16'h0000, 32'h0, 1'b0, 1'b1);
      cycle(16'h0000, 32'h0, 1'b0, 1'b1);
      chk("sb_empty", sb.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter ADDR_W, 32, width of program-counter bus.
REQ-002 Parameter INSTR_W, 16, width of one instruction-memory word.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 instr_in  input  INSTR_W  word currently output by fetch stage.
REQ-006 pc_in  input  ADDR_W  address of instr_in from fetch stage.
REQ-007 stall  input  1  hazard unit hold request; freezes buffer and fetch.
REQ-008 flush  input  1  branch/interrupt kill; discards buffered content.
REQ-009 fetch_en  output  1  enable to fetch stage PC circuit.
REQ-010 instr_out  output  INSTR_W  instruction word to decode.
REQ-011 imm_out  output  INSTR_W  immediate word to decode; 0 when none.
REQ-012 pc_out  output  ADDR_W  address of instr_out.
REQ-013 has_imm_out  output  1  instr_out carries valid imm_out.
REQ-014 valid_out  output  1  outputs hold a complete instruction this cycle.

Function
REQ-015 Immediate-bearing instruction SHALL be identified by opcode instr_in[15:11] with bits [4:3] == 2'b11.
REQ-016 FSM SHALL have two states: S_INSTR (expecting opcode word), S_IMM (expecting immediate word).
REQ-017 fetch_en SHALL be combinational: 1 when stall==0, else 0.
REQ-018 S_INSTR, no stall/flush, non-immediate word: next edge latch instr_out<=instr_in, pc_out<=pc_in, imm_out<=0, has_imm_out<=0, valid_out<=1; stay S_INSTR.
REQ-019 S_INSTR, no stall/flush, immediate word: next edge store word and pc in internal hold registers, valid_out<=0, instr_out<=NOP (16'h0000); go S_IMM.
REQ-020 S_IMM, no stall/flush: next edge instr_out<=held word, pc_out<=held pc, imm_out<=instr_in, has_imm_out<=1, valid_out<=1; go S_INSTR.
REQ-021 Latency SHALL be 1 cycle for non-immediate instructions, 2 cycles (one bubble) for immediate-bearing instructions.
REQ-022 stall==1, flush==0: all outputs, hold registers and state SHALL keep their values.
REQ-023 flush==1: next edge instr_out<=NOP, imm_out<=0, pc_out<=0, has_imm_out<=0, valid_out<=0, hold registers cleared, state<=S_INSTR.
REQ-024 flush and stall both 1: flush SHALL take priority; fetch_en still 0 that cycle.
REQ-025 flush in S_IMM SHALL discard the half-assembled instruction; no partial instruction SHALL ever reach outputs with valid_out==1.
REQ-026 Back-to-back immediate instructions SHALL each produce exactly one valid_out pulse, none lost or duplicated.
REQ-027 pc_out SHALL be passed without arithmetic; no wrap handling required.

Reset
REQ-028 rst==1 SHALL immediately force state S_INSTR, instr_out=NOP, imm_out=0, pc_out=0, has_imm_out=0, valid_out=0, hold registers 0.
REQ-029 rst asserted mid-S_IMM SHALL abandon the pending instruction; first post-reset edge behaves as REQ-018/019.
REQ-030 fetch_en SHALL be 1 during reset when stall==0.

Structure
REQ-031 Shared package SHALL hold NOP encoding, opcode field position [15:11], immediate-class opcode prefix 2'b11, state enum {S_INSTR,S_IMM}.
REQ-032 Immediate-detect SHALL be a package function, not a sub-module.
REQ-033 Block SHALL be a single module; no sub-module instantiated.

Verification
REQ-034 Reset, then instr_in=16'h0801,pc_in=32'h20 -> next edge instr_out=16'h0801, pc_out=32'h20, valid_out=1, has_imm_out=0.
REQ-035 instr_in=16'hC005,pc_in=32'h21 then 16'h1234,pc=32'h22 -> cycle1 valid_out=0; cycle2 instr_out=16'hC005, pc_out=32'h21, imm_out=16'h1234, has_imm_out=1, valid_out=1.
REQ-036 stall=1 for 3 cycles after valid output -> outputs unchanged, fetch_en=0 each cycle; release resumes with next word.
REQ-037 flush=1 while in S_IMM (after 16'hC005) -> next edge valid_out=0, instr_out=16'h0000; following word 16'h0801 treated as opcode.
REQ-038 stall=1 and flush=1 same cycle -> flush result per REQ-023, fetch_en=0.
REQ-039 rst pulse asynchronously mid-S_IMM -> outputs zero immediately without clock edge; subsequent 16'h0801 issues in 1 cycle.
